vlc_ook_tx: RTL and testbench

UART-framed on-off-keying transmitter that drives the VLC LED. It consumes the 9600 Hz square wave produced by the clock divider: it synchronises that wave into the 100 MHz clk_in domain and rising-edge detects it to get a one-cycle bit strobe. Bytes arrive over a valid/ready handshake and are serialised as start, data LSB-first, optional parity, then stop bits.

---
 rtl/vlc_pkg.sv | 16 +
 rtl/baud_edge_sync.sv | 29 ++
 rtl/vlc_ook_tx.sv | 118 +++++++++++
 tb/tb_vlc_ook_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vlc_pkg.sv
// Shared FSM encoding and OOK line levels for the VLC transmit/receive blocks.
package vlc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_e;

  localparam logic LINE_MARK  = 1'b1;
  localparam logic LINE_SPACE = 1'b0;

endpackage

// File: rtl/baud_edge_sync.sv
// Two-flop synchroniser for an asynchronous square wave plus a rising-edge
// detector producing a one-cycle tick in the clk_in domain.
module baud_edge_sync (
  input  logic clk_in,
  input  logic rst,
  input  logic async_in,
  output logic tick_out
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  // p0/p1: metastability filter; p2: previous synchronised level for edge detect
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= async_in;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign tick_out = sync_p1 & ~prev_p2;

endmodule

// File: rtl/vlc_ook_tx.sv
// UART-framed on-off-keying transmitter for the VLC LED, paced by the
// synchronised rising edges of the external baud square wave.
module vlc_ook_tx
  import vlc_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int OUT_INVERT = 0
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 led_out,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int             IDX_W     = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic           STOP_LAST = (STOP_BITS == 2);
  localparam logic           PAR_ODD   = (PARITY_ODD != 0);
  localparam logic           PIN_INV   = (OUT_INVERT != 0);

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (^d) ^ PAR_ODD;
  endfunction

  function automatic logic pin_level(input logic line);
    return line ^ PIN_INV;
  endfunction

  state_e               state;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_q;
  logic                 bit_tick;
  logic                 accept;

  baud_edge_sync u_sync (
    .clk_in  (clk_in),
    .rst     (rst),
    .async_in(baud_clk),
    .tick_out(bit_tick)
  );

  assign tx_ready = (state == IDLE) & ~rst;
  assign busy     = (state != IDLE);
  assign accept   = tx_valid & tx_ready;

  // Payload is held unreset; it is only consumed after an accept reloads it.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      shift_reg <= tx_data;
      parity_q  <= parity_of(tx_data);
    end else if (bit_tick && (state == START || state == DATA)) begin
      shift_reg <= shift_reg >> 1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      led_out    <= pin_level(LINE_MARK);
      frame_done <= 1'b0;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (accept) state <= ARMED;
        // Waiting for a fresh tick gives the start bit a full bit period.
        ARMED: if (bit_tick) begin
          state   <= START;
          led_out <= pin_level(LINE_SPACE);
        end
        START: if (bit_tick) begin
          state   <= DATA;
          led_out <= pin_level(shift_reg[0]);
          bit_idx <= '0;
        end
        DATA: if (bit_tick) begin
          if (bit_idx != LAST_IDX) begin
            bit_idx <= bit_idx + 1'b1;
            led_out <= pin_level(shift_reg[0]);
          end else if (PARITY_EN != 0) begin
            state   <= PARITY;
            led_out <= pin_level(parity_q);
          end else begin
            state    <= STOP;
            led_out  <= pin_level(LINE_MARK);
            stop_cnt <= 1'b0;
          end
        end
        PARITY: if (bit_tick) begin
          state    <= STOP;
          led_out  <= pin_level(LINE_MARK);
          stop_cnt <= 1'b0;
        end
        STOP: if (bit_tick) begin
          if (stop_cnt != STOP_LAST) begin
            stop_cnt <= 1'b1;
          end else begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vlc_ook_tx.sv
// Scoreboard bench: four transmitter variants share stimulus; each has a frame
// model queue filled on accept and a line monitor that decodes led_out.
module tb_vlc_ook_tx;

  localparam int NI = 4;
  localparam int SB_A  [NI] = '{1, 1, 2, 1};
  localparam int PE_A  [NI] = '{0, 1, 1, 0};
  localparam int PO_A  [NI] = '{0, 0, 1, 0};
  localparam int INV_A [NI] = '{0, 0, 0, 1};
  localparam logic [NI-1:0] INV_V = 4'b1000;
  localparam int BIT_CYC = 20;

  typedef struct {
    logic [15:0] bits;
    int          len;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          baud_clk = 1'b0;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_valid = 1'b0;
  logic [NI-1:0] ready_v, busy_v, led_v, done_v, pend_v;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int inst, input bit ok, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s inst %0d: got %0d expected %0d", nm, inst, act, exp);
    end
  endtask

  // Frame as it should appear on the wire: start, data LSB first, parity, stops.
  function automatic frame_t model(input logic [7:0] d, input int sb, input int pe, input int po);
    frame_t f;
    int n;
    f.bits = '0;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[1 + i] = d[i];
    n = 9;
    if (pe != 0) begin
      f.bits[n] = (($countones(d) % 2) == 1) ^ (po != 0);
      n++;
    end
    for (int s = 0; s < sb; s++) f.bits[n + s] = 1'b1;
    f.len = n + sb;
    return f;
  endfunction

  always #5 clk = ~clk;
  initial begin
    #2;
    forever #100 baud_clk = ~baud_clk;
  end

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam bit INV = (INV_A[g] != 0);
    logic   ready, busy_o, led, done;
    frame_t q[$];
    frame_t cur;
    bit     active = 1'b0;
    bit     pend;
    int     cnt;
    logic   line;
    logic   prev_line = 1'b1;

    vlc_ook_tx #(
      .DATA_BITS (8),
      .STOP_BITS (SB_A[g]),
      .PARITY_EN (PE_A[g]),
      .PARITY_ODD(PO_A[g]),
      .OUT_INVERT(INV_A[g])
    ) u_dut (
      .clk_in    (clk),
      .rst       (rst),
      .baud_clk  (baud_clk),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (ready),
      .led_out   (led),
      .busy      (busy_o),
      .frame_done(done)
    );

    assign ready_v[g] = ready;
    assign busy_v[g]  = busy_o;
    assign led_v[g]   = led;
    assign done_v[g]  = done;
    assign pend_v[g]  = pend;

    always @(posedge clk) begin
      if (!rst && tx_valid && ready) q.push_back(model(tx_data, SB_A[g], PE_A[g], PO_A[g]));
    end

    always @(negedge clk) begin
      line = led ^ INV;
      if (rst) begin
        q.delete();
        active = 1'b0;
      end else begin
        chk("busy_vs_ready", g, busy_o == !ready, int'(busy_o), int'(!ready));
        if (!active) begin
          if (done) chk("stray_frame_done", g, 1'b0, 1, 0);
          if (prev_line && !line) begin
            if (q.size() == 0) chk("unexpected_start", g, 1'b0, 1, 0);
            else begin
              cur = q.pop_front();
              active = 1'b1;
              cnt = 0;
            end
          end
        end else begin
          cnt++;
          if ((cnt % BIT_CYC) == BIT_CYC / 2 && (cnt / BIT_CYC) < cur.len) begin
            chk("line_bit", g, line == cur.bits[cnt / BIT_CYC], int'(line), int'(cur.bits[cnt / BIT_CYC]));
            chk("busy_in_frame", g, busy_o == 1'b1, int'(busy_o), 1);
          end
          if (done) begin
            chk("frame_done_time", g, cnt >= BIT_CYC * cur.len - 2 && cnt <= BIT_CYC * cur.len + 2,
                cnt, BIT_CYC * cur.len);
            chk("ready_at_done", g, ready && !busy_o, int'(ready), 1);
            active = 1'b0;
          end else if (cnt > BIT_CYC * cur.len + 2) begin
            chk("frame_done_timeout", g, 1'b0, cnt, BIT_CYC * cur.len);
            active = 1'b0;
          end
        end
      end
      pend = active || (q.size() != 0);
      prev_line = line;
    end
  end

  // Tick latency: high only in the cycle following the second edge after a rise.
  initial begin
    @(negedge rst);
    for (int p = 0; p < 3; p++) begin
      @(posedge baud_clk);
      @(negedge clk); chk("tick_rise_e1", p, g_dut[0].u_dut.bit_tick == 1'b0, int'(g_dut[0].u_dut.bit_tick), 0);
      @(negedge clk); chk("tick_rise_e2", p, g_dut[0].u_dut.bit_tick == 1'b1, int'(g_dut[0].u_dut.bit_tick), 1);
      @(negedge clk); chk("tick_rise_e3", p, g_dut[0].u_dut.bit_tick == 1'b0, int'(g_dut[0].u_dut.bit_tick), 0);
      @(negedge baud_clk);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk); chk("tick_on_fall", p, g_dut[0].u_dut.bit_tick == 1'b0, int'(g_dut[0].u_dut.bit_tick), 0);
      end
    end
  end

  task automatic wait_idle(input int max_cyc);
    int c;
    c = 0;
    while ((busy_v != '0 || pend_v != '0) && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    if (busy_v != '0 || pend_v != '0) chk("idle_timeout", 0, 1'b0, int'(busy_v), 0);
  endtask

  task automatic send_all(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin
    logic [NI-1:0] acc;
    int c;
    repeat (3) @(negedge clk);
    chk("rst_led", 0, led_v == ~INV_V, int'(led_v), int'(~INV_V));
    chk("rst_busy", 0, busy_v == '0, int'(busy_v), 0);
    chk("rst_done", 0, done_v == '0, int'(done_v), 0);
    chk("rst_ready", 0, ready_v == '0, int'(ready_v), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 0, ready_v == '1, int'(ready_v), 15);

    send_all(8'hA5);
    wait_idle(800);

    // Valid held high: 0x00 then 0xFF back-to-back, then data changes mid-frame.
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'hFF;
    acc = '0;
    c = 0;
    while (acc != '1 && c < 1000) begin
      @(negedge clk);
      acc |= ready_v;
      c++;
    end
    if (acc != '1) chk("b2b_accept_timeout", 0, 1'b0, int'(acc), 15);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (60) @(negedge clk);
    tx_data = 8'h3C;
    wait_idle(800);

    for (int i = 0; i < 2500; i++) begin
      tx_data  = 8'($urandom);
      tx_valid = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    wait_idle(1000);

    // Abort 0x0F during data bit 4, then send 0x81 cleanly.
    send_all(8'h0F);
    c = 0;
    while (led_v[0] != 1'b0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (led_v[0] != 1'b0) chk("start_timeout", 0, 1'b0, 1, 0);
    repeat (BIT_CYC * 5 + BIT_CYC / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_led", 0, led_v == ~INV_V, int'(led_v), int'(~INV_V));
    chk("abort_busy", 0, busy_v == '0, int'(busy_v), 0);
    chk("abort_done", 0, done_v == '0, int'(done_v), 0);
    chk("abort_ready", 0, ready_v == '0, int'(ready_v), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", 0, ready_v == '1, int'(ready_v), 15);
    repeat (30) @(negedge clk);
    send_all(8'h81);
    wait_idle(800);
    repeat (40) @(negedge clk);
    chk("final_idle", 0, busy_v == '0 && pend_v == '0, int'(busy_v | pend_v), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog inst 0: got timeout expected finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
